mem_stage: RTL and testbench

- Memory stage of the RV64I pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and consumes ALUResult_E / WriteData_E from execute.
- Runs a load/store unit with a req/gnt/rvalid handshake to data memory, and aligns/extends load data.
- Drives ALUResult_M back to execute for forwarding, and raises Stall_M to the hazard unit while an access is outstanding.

---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/load_extend.sv | 30 +++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg - shared LSU encodings, lane and fault helpers.   Rev 1.0
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic lsu_fault(input logic       rd,
                                     input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [2:0] off);
    logic misal;
    logic illegal;
    misal   = ((f3[1:0] == 2'b01) & off[0])
            | ((f3[1:0] == 2'b10) & (|off[1:0]))
            | ((f3[1:0] == 2'b11) & (|off));
    illegal = (rd & (f3 == 3'b111)) | (wr & f3[2]);
    return (rd | wr) & (misal | illegal);
  endfunction

  function automatic logic [7:0] lane_be(input logic [1:0] size,
                                         input logic [2:0] off);
    logic [7:0] be;
    case (size)
      2'b00:   be = 8'h01 << off;
      2'b01:   be = 8'h03 << off;
      2'b10:   be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_extend - selects the addressed bytes of a doubleword and extends.  Rev 1.0
// ---------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    ext = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   ext = {56'd0, shifted[7:0]};
      F3_HU:   ext = {48'd0, shifted[15:0]};
      F3_WU:   ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage - RV64I memory stage: EX/MEM register, LSU handshake, load align.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ALUResult_E,
  input  logic [XLEN-1:0] WriteData_E,
  input  logic [XLEN-1:0] PCPlus4_E,
  input  logic [4:0]      Rd_E,
  input  logic            RegWrite_E,
  input  logic            MemRead_E,
  input  logic            MemWrite_E,
  input  logic [1:0]      ResultSrc_E,
  input  logic [2:0]      funct3_E,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M,
  output logic            RegWrite_M,
  output logic [1:0]      ResultSrc_M,
  output logic [XLEN-1:0] ReadData_M,
  output logic            LsuFault_M,
  output logic            Stall_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  logic [4:0]      rd_q,         rd_d;
  logic            reg_write_q,  reg_write_d;
  logic            mem_read_q,   mem_read_d;
  logic            mem_write_q,  mem_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [2:0]      funct3_q,     funct3_d;
  lsu_state_t      state_q,      state_d;
  logic            done_q,       done_d;
  logic [XLEN-1:0] rdata_q,      rdata_d;

  logic memop_m;
  logic fault_m;
  logic fault_ex;
  logic stall_m;
  logic load_en;

  always_comb begin
    memop_m  = mem_read_q | mem_write_q;
    fault_m  = lsu_fault(mem_read_q, mem_write_q, funct3_q, alu_result_q[2:0]);
    fault_ex = lsu_fault(MemRead_E, MemWrite_E, funct3_E, ALUResult_E[2:0]);
    stall_m  = memop_m & ~fault_m & ~done_q;
    load_en  = ~stall_m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
      state_q      <= IDLE;
      done_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      state_q      <= state_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

  // The request is launched by the same edge that loads the op, so it is
  // visible at M together with the op itself.
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    state_d      = state_q;
    done_d       = done_q;
    rdata_d      = rdata_q;

    if (load_en) begin
      alu_result_d = ALUResult_E;
      write_data_d = WriteData_E;
      pc_plus4_d   = PCPlus4_E;
      rd_d         = Rd_E;
      reg_write_d  = RegWrite_E;
      mem_read_d   = MemRead_E;
      mem_write_d  = MemWrite_E;
      result_src_d = ResultSrc_E;
      funct3_d     = funct3_E;
      done_d       = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (load_en && (MemRead_E || MemWrite_E) && !fault_ex) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (mem_write_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Stall_M     = stall_m;
    LsuFault_M  = fault_m;
    RegWrite_M  = reg_write_q & ~fault_m;
    ALUResult_M = alu_result_q;
    PCPlus4_M   = pc_plus4_q;
    Rd_M        = rd_q;
    ResultSrc_M = result_src_q;
    dmem_req    = (state_q == REQ);
    dmem_we     = mem_write_q;
    dmem_addr   = {alu_result_q[XLEN-1:3], 3'b000};
    dmem_be     = lane_be(funct3_q[1:0], alu_result_q[2:0]);
    dmem_wdata  = write_data_q << {alu_result_q[2:0], 3'b000};
  end

  load_extend u_load_extend (
    .rdata  (rdata_q),
    .offset (alu_result_q[2:0]),
    .funct3 (funct3_q),
    .ext    (ReadData_M)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage - randomized scoreboard bench for mem_stage; expectations come
// from a byte-level model of the load/store rules and a scripted memory.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] alu_e, wd_e, pc4_e;
  logic [4:0]  rd_e;
  logic        rw_e, mr_e, mw_e;
  logic [1:0]  rs_e;
  logic [2:0]  f3_e;
  logic [63:0] ALUResult_M, PCPlus4_M, ReadData_M;
  logic [4:0]  Rd_M;
  logic        RegWrite_M, LsuFault_M, Stall_M;
  logic [1:0]  ResultSrc_M;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;

  mem_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResult_E(alu_e), .WriteData_E(wd_e), .PCPlus4_E(pc4_e), .Rd_E(rd_e),
    .RegWrite_E(rw_e), .MemRead_E(mr_e), .MemWrite_E(mw_e),
    .ResultSrc_E(rs_e), .funct3_E(f3_e),
    .ALUResult_M(ALUResult_M), .PCPlus4_M(PCPlus4_M), .Rd_M(Rd_M),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .ReadData_M(ReadData_M),
    .LsuFault_M(LsuFault_M), .Stall_M(Stall_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] alu, pc4, addr, wdata, rdata;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  be;
    logic        rw, fault, req, we, is_load, chk_rd;
    int          stall, reqs;
  } exp_t;

  typedef struct {
    int          gd, rdl;
    logic        is_load;
    logic [63:0] data;
  } rsp_t;

  exp_t sb[$];
  rsp_t rq[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   mon_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from the access rules, done byte by byte.
  function automatic exp_t model(input logic [63:0] alu, wd, pc4, input logic [4:0] rd,
                                 input logic rw, mr, mw, input logic [1:0] rs,
                                 input logic [2:0] f3, input int gd, rdl,
                                 input logic [63:0] mem);
    exp_t        e;
    int          off, n;
    logic        illegal, misal;
    logic [63:0] v, mask;
    off     = int'(alu[2:0]);
    n       = 1 << f3[1:0];
    illegal = (mr && f3 == 3'd7) || (mw && f3 >= 3'd4);
    misal   = (off % n) != 0;
    e.fault   = (mr || mw) && (illegal || misal);
    e.req     = (mr || mw) && !e.fault;
    e.is_load = mr && !mw;
    e.we      = mw;
    e.addr    = alu - 64'(off);
    e.wdata   = wd << (8 * off);
    for (int i = 0; i < 8; i++) e.be[i] = (i >= off) && (i < off + n);
    v = mem >> (8 * off);
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    e.rdata  = v;
    e.chk_rd = e.req && e.is_load;
    e.alu    = alu;
    e.pc4    = pc4;
    e.rd     = rd;
    e.rw     = rw && !e.fault;
    e.rs     = rs;
    e.stall  = e.req ? gd + 1 + (e.is_load ? rdl + 1 : 0) : 0;
    e.reqs   = e.req ? gd + 1 : 0;
    return e;
  endfunction

  // Drive one op on the _E inputs and hold it until the stage takes it.
  task automatic issue(input logic [63:0] alu, wd, pc4, input logic [4:0] rd,
                       input logic rw, mr, mw, input logic [1:0] rs,
                       input logic [2:0] f3, input int gd, rdl, input logic [63:0] mem);
    exp_t e;
    rsp_t r;
    bit   st;
    int   guard;
    alu_e = alu; wd_e = wd; pc4_e = pc4; rd_e = rd;
    rw_e = rw; mr_e = mr; mw_e = mw; rs_e = rs; f3_e = f3;
    st = Stall_M;
    guard = 0;
    while (st) begin
      @(posedge clk);
      #1;
      st = Stall_M;
      guard++;
      if (guard > 100) begin
        vectors++;
        errors++;
        $display("FAIL issue_timeout: Stall_M still %0b after %0d cycles", st, guard);
        return;
      end
    end
    @(posedge clk);
    e = model(alu, wd, pc4, rd, rw, mr, mw, rs, f3, gd, rdl, mem);
    sb.push_back(e);
    if (e.req) begin
      r.gd = gd; r.rdl = rdl; r.is_load = e.is_load; r.data = mem;
      rq.push_back(r);
    end
    #1;
  endtask

  task automatic bubble();
    issue(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 0, 0, 64'd0);
  endtask

  task automatic start_monitor();
    exp_t e;
    sb.delete();
    e = model(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 0, 0, 64'd0);
    e.chk_rd = 1'b1;
    sb.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int guard;
    bubble();
    bubble();
    guard = 0;
    while (sb.size() > 1 && guard < 20) begin
      bubble();
      guard++;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic rand_op();
    logic [63:0] alu;
    logic [2:0]  f3;
    logic        mr, mw, rw;
    logic [1:0]  rs;
    int          kind, n;
    alu  = {$urandom, $urandom};
    kind = int'($urandom_range(0, 3));
    mr = 1'b0; mw = 1'b0;
    rw = 1'($urandom_range(0, 1));
    rs = 2'd0;
    f3 = 3'($urandom_range(0, 7));
    case (kind)
      1: begin
        mr = 1'b1; rw = 1'b1; rs = 2'd1;
        f3 = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      end
      2: begin
        mw = 1'b1; rw = 1'b0;
        f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      end
      3: rs = 2'd2;
      default: rs = 2'd0;
    endcase
    n = 1 << f3[1:0];
    if ((mr || mw) && $urandom_range(0, 3) != 0) alu = alu & ~(64'(n) - 64'd1);
    issue(alu, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          rw, mr, mw, rs, f3, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          {$urandom, $urandom});
  endtask

  // Scripted data memory: grant/return timing comes from the issued op.
  initial begin : p_responder
    rsp_t r;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'd0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (rq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_request: dmem_req=1 addr %h with no access pending", dmem_addr);
        end else begin
          r = rq.pop_front();
          repeat (r.gd) @(negedge clk);
          dmem_gnt = 1'b1;
          @(negedge clk);
          dmem_gnt = 1'b0;
          if (r.is_load) begin
            repeat (r.rdl) @(negedge clk);
            dmem_rvalid = 1'b1;
            dmem_rdata  = r.data;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata  = {$urandom, $urandom};
          end
        end
      end
    end
  end

  initial begin : p_monitor
    int   stall_cnt;
    int   req_cnt;
    exp_t e;
    stall_cnt = 0;
    req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_cnt = 0;
        req_cnt   = 0;
      end else if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_empty: stage active (Stall_M=%0b) with no op expected", Stall_M);
      end else begin
        e = sb[0];
        if (dmem_req) begin
          req_cnt++;
          if (!e.req) begin
            vectors++;
            errors++;
            $display("FAIL spurious_req: dmem_req=1 for op at %h, required 0", e.alu);
          end else begin
            chk("dmem_we",    64'(dmem_we), 64'(e.we));
            chk("dmem_addr",  dmem_addr,    e.addr);
            chk("dmem_be",    64'(dmem_be), 64'(e.be));
            chk("dmem_wdata", dmem_wdata,   e.wdata);
          end
        end
        if (Stall_M) begin
          stall_cnt++;
        end else begin
          chk("ALUResult_M", ALUResult_M,       e.alu);
          chk("PCPlus4_M",   PCPlus4_M,         e.pc4);
          chk("Rd_M",        64'(Rd_M),         64'(e.rd));
          chk("RegWrite_M",  64'(RegWrite_M),   64'(e.rw));
          chk("ResultSrc_M", 64'(ResultSrc_M),  64'(e.rs));
          chk("LsuFault_M",  64'(LsuFault_M),   64'(e.fault));
          if (e.chk_rd) chk("ReadData_M", ReadData_M, e.rdata);
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
          chk("req_cycles",   64'(req_cnt),   64'(e.reqs));
          void'(sb.pop_front());
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end
    end
  end

  initial begin : p_main
    rst_n = 1'b0;
    alu_e = '0; wd_e = '0; pc4_e = '0; rd_e = '0;
    rw_e = 1'b0; mr_e = 1'b0; mw_e = 1'b0; rs_e = '0; f3_e = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_monitor();

    // LD, then LB/LBU of a negative byte, SH with slow grant, misaligned LW, ADD then LD
    issue(64'h1000, 64'd0, 64'h104, 5'd5, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 0, 0, 64'h8877665544332211);
    issue(64'h1005, 64'd0, 64'h108, 5'd6, 1'b1, 1'b1, 1'b0, 2'd1, 3'd0, 1, 1, 64'h000080FF00000000);
    issue(64'h1005, 64'd0, 64'h10C, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 3'd4, 0, 2, 64'h000080FF00000000);
    issue(64'h2002, 64'hABCD, 64'h110, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 3, 0, 64'd0);
    issue(64'h3002, 64'd0, 64'h114, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 3'd2, 0, 0, 64'd0);
    issue(64'h55, 64'd0, 64'h118, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0, 0, 64'd0);
    issue(64'h1000, 64'd0, 64'h11C, 5'd10, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 0, 0, 64'hCAFEF00D12345678);

    for (int i = 0; i < 150; i++) rand_op();
    drain();

    // Reset lands in WAIT on the same edge as rvalid.
    issue(64'h4008, 64'd0, 64'h200, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 0, 1, 64'h1122334455667788);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("wait_stall", 64'(Stall_M), 64'd1);
    rst_n = 1'b0;
    alu_e = '0; wd_e = '0; pc4_e = '0; rd_e = '0;
    rw_e = 1'b0; mr_e = 1'b0; mw_e = 1'b0; rs_e = '0; f3_e = '0;
    @(posedge clk);
    #1;
    chk("rst_stall",    64'(Stall_M),    64'd0);
    chk("rst_req",      64'(dmem_req),   64'd0);
    chk("rst_alu",      ALUResult_M,     64'd0);
    chk("rst_rdata",    ReadData_M,      64'd0);
    chk("rst_fault",    64'(LsuFault_M), 64'd0);
    chk("rst_regwrite", 64'(RegWrite_M), 64'd0);
    chk("rst_rd",       64'(Rd_M),       64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_req",   64'(dmem_req), 64'd0);
      chk("post_rst_stall", 64'(Stall_M),  64'd0);
      chk("post_rst_rdata", ReadData_M,    64'd0);
    end

    start_monitor();
    for (int i = 0; i < 20; i++) rand_op();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
